// File: rtl/maxpool_ser_win.sv
// Serial-input max pooling: every channel receives its samples as NB chunks (LSB first),
// and the block emits the per-channel maximum over non-overlapping windows of POOL samples.
module maxpool_ser_win #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 8,
  parameter int SER_BW = 4,
  parameter int POOL   = 2,
  parameter int SIGNED = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vld_in,
  input  logic [NO_CH-1:0][SER_BW-1:0]     data_in,
  input  logic                             last_in,
  output logic                             vld_out,
  output logic [NO_CH-1:0][BW_IN-1:0]      data_out,
  output logic                             last_out
);

  localparam int NB  = BW_IN / SER_BW;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SCW = $clog2(POOL);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(NB - 1);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(POOL - 1);

  logic [BCW-1:0]                r_beat;
  logic [SCW-1:0]                r_samp;
  logic [NO_CH-1:0][BW_IN-1:0]   r_max;
  logic [NO_CH-1:0][BW_IN-1:0]   r_data;
  logic                          r_vld;
  logic                          r_last;

  logic [NO_CH-1:0][BW_IN-1:0]   w_sample;
  logic [NO_CH-1:0][BW_IN-1:0]   w_newmax;
  logic                          w_done;
  logic                          w_close;

  assign w_done  = vld_in && (r_beat == BEAT_LAST);
  assign w_close = (r_samp == SAMP_LAST) || last_in;

  // The final chunk is never stored: it is taken straight from data_in on the completing beat.
  generate
    if (NB > 1) begin : g_part
      logic [NO_CH-1:0][BW_IN-SER_BW-1:0] r_part;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_part <= '0;
        end else if (vld_in && (r_beat != BEAT_LAST)) begin
          for (int c = 0; c < NO_CH; c++) begin
            r_part[c][SER_BW*r_beat +: SER_BW] <= data_in[c];
          end
        end
      end

      always_comb begin
        for (int c = 0; c < NO_CH; c++) begin
          w_sample[c] = {data_in[c], r_part[c]};
        end
      end
    end else begin : g_nopart
      always_comb begin
        for (int c = 0; c < NO_CH; c++) begin
          w_sample[c] = data_in[c];
        end
      end
    end
  endgenerate

  function automatic logic isGreater(input logic [BW_IN-1:0] a, input logic [BW_IN-1:0] b);
    if (SIGNED != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Sample 0 of a window always loads; later samples replace only when strictly greater.
  always_comb begin
    for (int c = 0; c < NO_CH; c++) begin
      w_newmax[c] = r_max[c];
      if ((r_samp == '0) || isGreater(w_sample[c], r_max[c])) begin
        w_newmax[c] = w_sample[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_samp <= '0;
      r_max  <= '0;
      r_data <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (vld_in) begin
        r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BCW'(1);
      end
      if (w_done) begin
        if (w_close) begin
          r_data <= w_newmax;
          r_vld  <= 1'b1;
          r_last <= last_in;
          r_samp <= '0;
        end else begin
          r_max  <= w_newmax;
          r_samp <= r_samp + SCW'(1);
        end
      end
    end
  end

  assign vld_out  = r_vld;
  assign data_out = r_data;
  assign last_out = r_last;

endmodule

// File: tb/tb_maxpool_ser_win.sv
// Bench for maxpool_ser_win: an unsigned and a signed instance share one input stream
// (NO_CH=2, BW_IN=8, SER_BW=4, POOL=3, ch1 = ch0 ^ 0xFF).
module tb_maxpool_ser_win;

  logic            clk;
  logic            rst;
  logic            vld_in;
  logic [1:0][3:0] din;
  logic            last_in;
  logic            vld_u, vld_s;
  logic [1:0][7:0] dout_u, dout_s;
  logic            last_u, last_s;

  int total = 0;
  int bad   = 0;
  int pulseCnt = 0;
  int cyc = 0;
  logic [7:0] qData[$];
  int         qCyc[$];

  maxpool_ser_win #(.NO_CH(2), .BW_IN(8), .SER_BW(4), .POOL(3), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(din), .last_in(last_in),
    .vld_out(vld_u), .data_out(dout_u), .last_out(last_u));

  maxpool_ser_win #(.NO_CH(2), .BW_IN(8), .SER_BW(4), .POOL(3), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(din), .last_in(last_in),
    .vld_out(vld_s), .data_out(dout_s), .last_out(last_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are logged at the following edge, so the logged values are those of the pulse cycle.
  always @(posedge clk) begin
    if (vld_u) begin
      pulseCnt++;
      qData.push_back(dout_u[0]);
      qCyc.push_back(cyc);
    end
    cyc++;
  end

  typedef struct {
    string           nm;
    logic [2:0][7:0] s;
    int              n;
    logic            lst;
    logic [7:0]      eu0, eu1, es0, es1;
    logic            el;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic lastEnd, input logic lastBeat0);
    logic [7:0] x;
    x = s ^ 8'hFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vld_in  = 1'b1;
      din[0]  = s[4*k +: 4];
      din[1]  = x[4*k +: 4];
      last_in = (k == 1) ? lastEnd : lastBeat0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    vld_in  = 1'b0;
    last_in = 1'b0;
    din     = '0;
  endtask

  task automatic checkWindow(input string nm, input logic [7:0] eu0, input logic [7:0] eu1,
                             input logic [7:0] es0, input logic [7:0] es1, input logic el);
    idle();
    checkOutput({nm, "_vld_u"}, vld_u, 1);
    checkOutput({nm, "_vld_s"}, vld_s, 1);
    checkOutput({nm, "_u0"}, dout_u[0], eu0);
    checkOutput({nm, "_u1"}, dout_u[1], eu1);
    checkOutput({nm, "_s0"}, dout_s[0], es0);
    checkOutput({nm, "_s1"}, dout_s[1], es1);
    checkOutput({nm, "_last_u"}, last_u, el);
    checkOutput({nm, "_last_s"}, last_s, el);
    idle();
    checkOutput({nm, "_drop"}, vld_u, 0);
    checkOutput({nm, "_hold_u0"}, dout_u[0], eu0);
    checkOutput({nm, "_hold_last"}, last_u, el);
  endtask

  task automatic checkZero(input string nm);
    checkOutput({nm, "_vld"}, {vld_u, vld_s}, 0);
    checkOutput({nm, "_last"}, {last_u, last_s}, 0);
    checkOutput({nm, "_data_u"}, dout_u, 0);
    checkOutput({nm, "_data_s"}, dout_s, 0);
  endtask

  initial begin
    logic [7:0] gapSmp[3];
    int cnt0, q0;

    vecs[0] = '{"basic",   {8'h05, 8'h7F, 8'h12}, 3, 1'b0, 8'h7F, 8'hFA, 8'h7F, 8'hFA, 1'b0};
    vecs[1] = '{"sign",    {8'h01, 8'hFF, 8'h80}, 3, 1'b0, 8'hFF, 8'hFE, 8'h01, 8'h7F, 1'b0};
    vecs[2] = '{"tie",     {8'h44, 8'h44, 8'h44}, 3, 1'b0, 8'h44, 8'hBB, 8'h44, 8'hBB, 1'b0};
    vecs[3] = '{"negone",  {8'hFF, 8'h00, 8'h00}, 3, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{"early",   {8'h00, 8'h20, 8'h10}, 2, 1'b1, 8'h20, 8'hEF, 8'h20, 8'hEF, 1'b1};
    vecs[5] = '{"after",   {8'h03, 8'h02, 8'h01}, 3, 1'b0, 8'h03, 8'hFE, 8'h03, 8'hFE, 1'b0};
    vecs[6] = '{"single",  {8'h00, 8'h00, 8'h5A}, 1, 1'b1, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 1'b1};
    vecs[7] = '{"lastfull",{8'h03, 8'h02, 8'h01}, 3, 1'b1, 8'h03, 8'hFE, 8'h03, 8'hFE, 1'b1};
    vecs[8] = '{"mixed",   {8'h81, 8'h3C, 8'hC3}, 3, 1'b0, 8'hC3, 8'hC3, 8'h3C, 8'h7E, 1'b0};

    rst = 1'b1; vld_in = 1'b0; last_in = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk);
    checkZero("reset");
    rst = 1'b0;

    // Gapped stream: three idle cycles after every beat, outputs must not move in the gaps.
    gapSmp = '{8'h12, 8'h7F, 8'h05};
    cnt0 = pulseCnt;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        vld_in = 1'b1;
        din[0] = gapSmp[j][4*k +: 4];
        din[1] = ~gapSmp[j][4*k +: 4];
        last_in = 1'b0;
        for (int g = 0; g < 3; g++) begin
          idle();
          if (j == 2 && k == 1 && g == 0) begin
            checkOutput("gap_pulse", vld_u, 1);
            checkOutput("gap_u0", dout_u[0], 8'h7F);
            checkOutput("gap_u1", dout_u[1], 8'hFA);
            checkOutput("gap_last", last_u, 0);
          end else begin
            checkOutput("gap_idle_vld", vld_u, 0);
            checkOutput("gap_idle_u0", dout_u[0], (j == 2 && k == 1) ? 8'h7F : 8'h00);
          end
        end
      end
    end
    checkOutput("gap_pulsecount", pulseCnt, cnt0 + 1);

    for (int v = 0; v < 9; v++) begin
      cnt0 = pulseCnt;
      for (int j = 0; j < vecs[v].n; j++) begin
        applyStimulus(vecs[v].s[j], (j == vecs[v].n - 1) ? vecs[v].lst : 1'b0, 1'b0);
      end
      checkWindow(vecs[v].nm, vecs[v].eu0, vecs[v].eu1, vecs[v].es0, vecs[v].es1, vecs[v].el);
      checkOutput({vecs[v].nm, "_pulses"}, pulseCnt, cnt0 + 1);
    end

    // last_in raised on a non-final beat must not close the window.
    cnt0 = pulseCnt;
    applyStimulus(8'h11, 1'b0, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b1);
    idle();
    checkOutput("nonfinal_last_vld", vld_u, 0);
    applyStimulus(8'h33, 1'b0, 1'b0);
    checkWindow("nonfinal", 8'h33, 8'hEE, 8'h33, 8'hEE, 1'b0);
    checkOutput("nonfinal_pulses", pulseCnt, cnt0 + 1);

    // Reset in the middle of a window, with half a sample already captured.
    applyStimulus(8'h7F, 1'b0, 1'b0);
    @(negedge clk);
    vld_in = 1'b1; din[0] = 4'hF; din[1] = 4'h0; last_in = 1'b0;
    @(negedge clk);
    vld_in = 1'b0;
    rst = 1'b1;
    #1;
    checkZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    checkWindow("postrst", 8'h03, 8'hFE, 8'h03, 8'hFE, 1'b0);

    // Back-to-back windows at full rate.
    q0 = qData.size();
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h09, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b0, 1'b0);
    checkWindow("b2b", 8'h09, 8'hF8, 8'h09, 8'hF8, 1'b0);
    idle();
    checkOutput("b2b_count", qData.size() - q0, 2);
    if (qData.size() - q0 == 2) begin
      checkOutput("b2b_first", qData[q0], 8'h03);
      checkOutput("b2b_second", qData[q0+1], 8'h09);
      checkOutput("b2b_spacing", qCyc[q0+1] - qCyc[q0], 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_ser_win.md
MAXPOOL_SER_WIN -- requirements
Module: maxpool_ser_win

Interface
REQ-001 SHALL have parameter NO_CH, default 10: number of independent channels.
REQ-002 SHALL have parameter BW_IN, default 8: bits per sample per channel.
REQ-003 SHALL have parameter SER_BW, default 4: bits per channel per input beat; SER_BW SHALL divide BW_IN; NB = BW_IN/SER_BW beats per sample.
REQ-004 SHALL have parameter POOL, default 2: samples per pooling window, at least 2; stride equals POOL, so windows do not overlap.
REQ-005 SHALL have parameter SIGNED, default 0: 0 means unsigned compare, 1 means two's-complement compare.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port vld_in, input, 1 bit: a beat is accepted on a rising clk edge when this is high.
REQ-009 SHALL have port data_in, input, [NO_CH][SER_BW]: one serial chunk per channel.
REQ-010 SHALL have port last_in, input, 1 bit: end-of-frame marker, qualified by vld_in on the final beat of a sample.
REQ-011 SHALL have port vld_out, output, 1 bit: one-cycle pulse marking a new pooled result.
REQ-012 SHALL have port data_out, output, [NO_CH][BW_IN]: per-channel window maximum.
REQ-013 SHALL have port last_out, output, 1 bit: high with vld_out when the result was closed by last_in.

Function
REQ-014 SHALL assemble each sample LSB chunk first: beat k of a sample supplies bits [SER_BW*k +: SER_BW], for k = 0..NB-1.
REQ-015 SHALL use a beat counter 0..NB-1 that advances only on accepted beats and wraps to 0 after beat NB-1.
REQ-016 SHALL tolerate any number of idle cycles (vld_in low) between beats with no change of state or outputs.
REQ-017 SHALL complete a sample on the accepted beat NB-1, using the registered partial chunks concatenated with the current data_in chunk.
REQ-018 SHALL use a sample counter 0..POOL-1 that advances on each completed sample.
REQ-019 SHALL load the running max per channel from the first sample of a window (sample count 0) and replace it on later samples only when the new sample is strictly greater.
REQ-020 SHALL compare unsigned when SIGNED=0 and two's-complement when SIGNED=1; on ties the result value is the same either way.
REQ-021 SHALL close a window when the completed sample is sample POOL-1, or when last_in=1 on that final beat, whichever occurs first.
REQ-022 SHALL, on the clk edge that closes a window, register data_out = max(running max, completing sample), set vld_out=1, set last_out=last_in, and reset the sample counter to 0.
REQ-023 SHALL have a latency of 1 cycle: vld_out is high in the cycle after the closing beat edge, and falls after one cycle unless another window closes on that edge.
REQ-024 SHALL hold data_out and last_out stable between pulses.
REQ-025 SHALL produce exactly one pulse, with last_out=1, when last_in coincides with sample POOL-1.
REQ-026 SHALL ignore last_in on non-final beats of a sample; a partial sample is never emitted.
REQ-027 SHALL accept back-to-back windows at full rate: the next window's beat 0 may arrive on the edge after the closing beat.

Reset
REQ-028 SHALL, while rst is high, asynchronously force vld_out=0, last_out=0, data_out=0, beat and sample counters to 0, and running max and partial chunks to 0.
REQ-029 SHALL discard any partial sample or window when rst is asserted mid-window; the first beat accepted after rst deasserts is beat 0 of sample 0.

Verification (NO_CH=2, BW_IN=8, SER_BW=4, POOL=3; ch1 = ch0 XOR 0xFF unless stated)
REQ-030 SHALL cover unsigned pooling, SIGNED=0: ch0 samples 0x12, 0x7F, 0x05 over 6 consecutive beats -> vld_out pulses one cycle after beat 6; data_out ch0=0x7F, ch1=0xFA; last_out=0.
REQ-031 SHALL cover signed pooling, SIGNED=1: ch0 samples 0x80, 0xFF, 0x01 -> ch0=0x01 (SIGNED=0 gives 0xFF).
REQ-032 SHALL cover gapped input: the REQ-030 stream with 3 idle cycles between every pair of beats -> identical result, a single pulse, and no output change during the gaps.
REQ-033 SHALL cover early close: samples 0x10, 0x20 with last_in on beat 4 -> ch0=0x20 with last_out=1; then 0x01, 0x02, 0x03 -> ch0=0x03 with last_out=0.
REQ-034 SHALL cover reset mid-window: after 0x7F and one beat of the next sample, pulse rst -> outputs read 0; then 0x01, 0x02, 0x03 -> ch0=0x03, not 0x7F.
REQ-035 SHALL cover back-to-back windows: 0x01, 0x02, 0x03 then 0x09, 0x08, 0x07 with no gaps -> ch0=0x03 then 0x09, with pulses exactly 6 cycles apart.
